// File: rtl/tc_mul_pkg.sv
// Shared widths, saturation limits and the fit/clamp/wrap decision for tc_mul_pipe.
// Everything is evaluated on a 64-bit signed carrier wide enough for any legal width combination.
package tc_mul_pkg;

   localparam int MAX_W = 64;

   typedef logic signed [MAX_W-1:0] wide_t;

   typedef struct packed {
      logic             ovf;
      logic [MAX_W-1:0] val;
   } fit_t;

   function automatic int full_w(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   function automatic int rnd_w(input int a_w, input int b_w);
      return a_w + b_w + 1;
   endfunction

   function automatic wide_t sat_max(input int p_w);
      return (wide_t'(1) <<< (p_w - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t sat_min(input int p_w);
      return -(wide_t'(1) <<< (p_w - 1));
   endfunction

   // Caller keeps val[p_w-1:0]; the wrap case therefore just passes s through.
   function automatic fit_t fit_clamp(input wide_t s, input int p_w, input logic sat);
      fit_t  r;
      wide_t mx;
      wide_t mn;
      mx    = sat_max(p_w);
      mn    = sat_min(p_w);
      r.ovf = (s > mx) || (s < mn);
      if (r.ovf && sat) begin
         r.val = s[MAX_W-1] ? mn : mx;
      end else begin
         r.val = s;
      end
      return r;
   endfunction

endpackage

// File: rtl/tc_mul_stage.sv
// One clock-enabled pipeline register carrying a data word and its valid bit.
// Synchronous reset clears both and overrides the clock enable.
module tc_mul_stage #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_ce,
   input  logic         i_vld,
   input  logic [W-1:0] i_dat,
   output logic         o_vld,
   output logic [W-1:0] o_dat
);

   logic         r_vld;
   logic [W-1:0] r_dat;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld <= 1'b0;
         r_dat <= '0;
      end else if (i_ce) begin
         r_vld <= i_vld;
         r_dat <= i_dat;
      end
   end

   assign o_vld = r_vld;
   assign o_dat = r_dat;

endmodule

// File: rtl/tc_mul_pipe.sv
// Pipelined signed x unsigned multiply with optional round/shift and saturate-or-wrap to P_WIDTH.
// Latency NUM_STAGE enabled cycles, one op per enabled cycle; ce=0 freezes every stage.
module tc_mul_pipe
   import tc_mul_pkg::*;
#(
   parameter int A_WIDTH   = 17,
   parameter int B_WIDTH   = 10,
   parameter int P_WIDTH   = 26,
   parameter int NUM_STAGE = 3,
   parameter int SHIFT     = 0,
   parameter int ROUND     = 0,
   parameter int SATURATE  = 0
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      ce,
   input  logic                      in_valid,
   input  logic signed [A_WIDTH-1:0] din0,
   input  logic        [B_WIDTH-1:0] din1,
   output logic                      out_valid,
   output logic signed [P_WIDTH-1:0] dout,
   output logic                      ovf
);

   localparam int FW    = full_w(A_WIDTH, B_WIDTH);
   localparam int RW    = rnd_w(A_WIDTH, B_WIDTH);
   localparam int NPROD = (NUM_STAGE >= 3) ? NUM_STAGE - 2 : 0;
   localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [RW-1:0] RND = (ROUND != 0 && SHIFT > 0) ?
                                   ({{(RW-1){1'b0}}, 1'b1} << RSH) : '0;

   logic          w_op_vld;
   logic [FW-1:0] w_op_dat;

   generate
      if (NUM_STAGE >= 2) begin : g_op
         tc_mul_stage #(.W(FW)) u_op (
            .i_clk (ap_clk),
            .i_rst (ap_rst),
            .i_ce  (ce),
            .i_vld (in_valid),
            .i_dat ({din0, din1}),
            .o_vld (w_op_vld),
            .o_dat (w_op_dat)
         );
      end else begin : g_op_bypass
         assign w_op_vld = in_valid;
         assign w_op_dat = {din0, din1};
      end
   endgenerate

   logic [A_WIDTH-1:0] w_a;
   logic [B_WIDTH-1:0] w_b;
   logic [FW-1:0]      w_a_ext;
   logic [FW-1:0]      w_b_ext;
   logic [FW-1:0]      w_prod;

   // Product of a signed A-bit and a non-negative B-bit value always fits FW bits,
   // so the low FW bits of the extended multiply are exact.
   assign w_a     = w_op_dat[FW-1:B_WIDTH];
   assign w_b     = w_op_dat[B_WIDTH-1:0];
   assign w_a_ext = {{B_WIDTH{w_a[A_WIDTH-1]}}, w_a};
   assign w_b_ext = {{A_WIDTH{1'b0}}, w_b};
   assign w_prod  = w_a_ext * w_b_ext;

   logic [FW-1:0] w_pd [0:NPROD];
   logic          w_pv [0:NPROD];

   assign w_pd[0] = w_prod;
   assign w_pv[0] = w_op_vld;

   generate
      for (genvar gi = 0; gi < NPROD; gi++) begin : g_prod
         tc_mul_stage #(.W(FW)) u_prod (
            .i_clk (ap_clk),
            .i_rst (ap_rst),
            .i_ce  (ce),
            .i_vld (w_pv[gi]),
            .i_dat (w_pd[gi]),
            .o_vld (w_pv[gi+1]),
            .o_dat (w_pd[gi+1])
         );
      end
   endgenerate

   logic signed [RW-1:0] w_r;
   logic signed [RW-1:0] w_s;
   wide_t                w_s64;
   fit_t                 w_fit;
   logic                 w_unused_hi;
   logic [P_WIDTH:0]     w_out_dat;

   assign w_r         = $signed({w_pd[NPROD][FW-1], w_pd[NPROD]} + RND);
   assign w_s         = w_r >>> SHIFT;
   assign w_s64       = {{(MAX_W-RW){w_s[RW-1]}}, w_s};
   assign w_fit       = fit_clamp(w_s64, P_WIDTH, SATURATE != 0);
   assign w_unused_hi = ^w_fit.val[MAX_W-1:P_WIDTH];

   tc_mul_stage #(.W(P_WIDTH+1)) u_out (
      .i_clk (ap_clk),
      .i_rst (ap_rst),
      .i_ce  (ce),
      .i_vld (w_pv[NPROD]),
      .i_dat ({w_fit.ovf, w_fit.val[P_WIDTH-1:0]}),
      .o_vld (out_valid),
      .o_dat (w_out_dat)
   );

   assign ovf  = w_out_dat[P_WIDTH];
   assign dout = w_out_dat[P_WIDTH-1:0];

endmodule

// File: tb/tb_tc_mul_pipe.sv
// Drives seven tc_mul_pipe configurations from one operand stream and checks each against
// an arithmetic model indexed by enabled-edge count.
module tb_tc_mul_pipe;

   logic               ap_clk = 1'b0;
   logic               ap_rst;
   logic               ce;
   logic               in_valid;
   logic signed [16:0] din0;
   logic        [9:0]  din1;

   always #5 ap_clk = ~ap_clk;

   // 0:D sat  1:W wrap  2:R P22 sh4 rnd  3:R0 P22 sh4  4:N1  5:N2  6:N4
   int NS [7] = '{3, 3, 3, 3, 1, 2, 4};
   int SH [7] = '{0, 0, 4, 4, 0, 0, 0};
   int RN [7] = '{0, 0, 1, 0, 0, 0, 0};
   int PW [7] = '{26, 26, 22, 22, 26, 26, 26};
   int SA [7] = '{1, 0, 0, 0, 1, 1, 1};
   int SWI [4] = '{4, 5, 0, 6};

   logic        vld  [7];
   logic        ovfv [7];
   logic [25:0] dv   [7];

   logic signed [25:0] d0, d1, d4, d5, d6;
   logic signed [21:0] d2, d3;

   assign dv[0] = d0;
   assign dv[1] = d1;
   assign dv[2] = {4'b0000, d2};
   assign dv[3] = {4'b0000, d3};
   assign dv[4] = d4;
   assign dv[5] = d5;
   assign dv[6] = d6;

   tc_mul_pipe #(.P_WIDTH(26), .NUM_STAGE(3), .SATURATE(1)) u_d (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[0]), .dout(d0), .ovf(ovfv[0]));
   tc_mul_pipe #(.P_WIDTH(26), .NUM_STAGE(3), .SATURATE(0)) u_w (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[1]), .dout(d1), .ovf(ovfv[1]));
   tc_mul_pipe #(.P_WIDTH(22), .NUM_STAGE(3), .SHIFT(4), .ROUND(1), .SATURATE(0)) u_r (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[2]), .dout(d2), .ovf(ovfv[2]));
   tc_mul_pipe #(.P_WIDTH(22), .NUM_STAGE(3), .SHIFT(4), .ROUND(0), .SATURATE(0)) u_r0 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[3]), .dout(d3), .ovf(ovfv[3]));
   tc_mul_pipe #(.P_WIDTH(26), .NUM_STAGE(1), .SATURATE(1)) u_n1 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[4]), .dout(d4), .ovf(ovfv[4]));
   tc_mul_pipe #(.P_WIDTH(26), .NUM_STAGE(2), .SATURATE(1)) u_n2 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[5]), .dout(d5), .ovf(ovfv[5]));
   tc_mul_pipe #(.P_WIDTH(26), .NUM_STAGE(4), .SATURATE(1)) u_n4 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
      .out_valid(vld[6]), .dout(d6), .ovf(ovfv[6]));

   int n_chk  = 0;
   int n_fail = 0;

   bit     hv [4096];
   longint ha [4096];
   longint hb [4096];
   int     ecnt     = 0;
   bit     rst_just = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] msk(input longint v, input int p);
      return 64'(v) & ((64'd1 << p) - 64'd1);
   endfunction

   function automatic longint mdl(input longint a, input longint b, input int sh, input int rnd,
                                  input int p, input int sat, output bit o);
      longint f, r, s, mx, mn;
      f  = a * b;
      r  = f + ((rnd != 0 && sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
      s  = r >>> sh;
      mx = (longint'(1) << (p - 1)) - 1;
      mn = -(longint'(1) << (p - 1));
      o  = (s > mx) || (s < mn);
      if (o && sat != 0) return (s > mx) ? mx : mn;
      return s;
   endfunction

   task automatic check_all();
      for (int i = 0; i < 7; i++) begin
         int     idx;
         longint e;
         bit     eo;
         idx = ecnt - NS[i];
         if (idx >= 0 && hv[idx]) begin
            e = mdl(ha[idx], hb[idx], SH[i], RN[i], PW[i], SA[i], eo);
            chk($sformatf("i%0d_vld_e%0d", i, ecnt), 64'(vld[i]), 64'd1);
            chk($sformatf("i%0d_dout_e%0d", i, ecnt), 64'(dv[i]), msk(e, PW[i]));
            chk($sformatf("i%0d_ovf_e%0d", i, ecnt), 64'(ovfv[i]), 64'(eo));
         end else begin
            chk($sformatf("i%0d_novld_e%0d", i, ecnt), 64'(vld[i]), 64'd0);
         end
         if (rst_just) begin
            chk($sformatf("i%0d_rst_dout", i), 64'(dv[i]), 64'd0);
            chk($sformatf("i%0d_rst_ovf", i), 64'(ovfv[i]), 64'd0);
         end
      end
   endtask

   task automatic cyc(input bit r, input bit c, input bit v, input longint a, input longint b);
      ap_rst   = r;
      ce       = c;
      in_valid = v;
      din0     = a[16:0];
      din1     = b[9:0];
      if (r) begin
         for (int j = 0; j < ecnt; j++) hv[j] = 1'b0;
         rst_just = 1'b1;
      end else if (c) begin
         hv[ecnt] = v;
         ha[ecnt] = a;
         hb[ecnt] = b;
         ecnt++;
         rst_just = 1'b0;
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
      check_all();
   endtask

   function automatic longint ra();
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) return -65536;
      if (sel == 1) return 65535;
      return longint'($urandom_range(0, 131071)) - 65536;
   endfunction

   function automatic longint rb();
      if ($urandom_range(0, 7) == 0) return 1023;
      return longint'($urandom_range(0, 1023));
   endfunction

   initial begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 7, 7);

      // Basic product, visible after three enabled edges.
      cyc(0, 1, 1, -5, 7);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("dir_m35_vld", 64'(vld[0]), 64'd1);
      chk("dir_m35_dout", 64'(dv[0]), msk(-35, 26));
      chk("dir_m35_ovf", 64'(ovfv[0]), 64'd0);

      // Overflow: saturate vs wrap.
      cyc(0, 1, 1, -65536, 1023);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("ovf_sat_dout", 64'(dv[0]), msk(-33554432, 26));
      chk("ovf_sat_ovf", 64'(ovfv[0]), 64'd1);
      chk("ovf_wrap_dout", 64'(dv[1]), msk(65536, 26));
      chk("ovf_wrap_ovf", 64'(ovfv[1]), 64'd1);

      // Rounding at SHIFT=4.
      cyc(0, 1, 1, 25, 1);
      cyc(0, 1, 1, -25, 1);
      cyc(0, 1, 0, 0, 0);
      chk("rnd_p25", 64'(dv[2]), msk(2, 22));
      chk("trunc_p25", 64'(dv[3]), msk(1, 22));
      cyc(0, 1, 0, 0, 0);
      chk("rnd_m25", 64'(dv[2]), msk(-2, 22));

      // Latency sweep with the largest operands.
      cyc(0, 1, 1, 65535, 1023);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc(0, 1, 0, 0, 0);
         chk($sformatf("sweep_ns%0d_vld", k + 1), 64'(vld[SWI[k]]), 64'd1);
         chk($sformatf("sweep_ns%0d_dout", k + 1), 64'(dv[SWI[k]]), msk(33554431, 26));
      end

      for (int k = 0; k < 100; k++) cyc(0, 1, 1, ra(), rb());
      for (int k = 0; k < 250; k++)
         cyc(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ra(), rb());

      // Reset with ops in flight, once with ce=1 and once with ce=0.
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, ra(), rb());
      cyc(1, 1, 1, ra(), rb());
      chk("rst_ce1_vld", 64'(vld[6]), 64'd0);
      for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, ra(), rb());
      cyc(1, 0, 1, ra(), rb());
      chk("rst_ce0_vld", 64'(vld[0]), 64'd0);
      cyc(0, 0, 1, ra(), rb());
      for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0);

      for (int k = 0; k < 80; k++)
         cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra(), rb());
      for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tc_mul_pipe.md
# tc_mul_pipe

Parametrised, pipelined signed × unsigned multiplier for the TrackletCalculator datapath; successor to the fixed 17s×10ns single-cycle multiplier cores. Multiplies a signed operand by an unsigned operand, optionally rounds and arithmetically right-shifts the product, then wraps or saturates it to the output width. The block carries a valid bit alongside the data and honours an HLS-style clock enable, so it drops into `ap_ctrl` pipelines with a fixed, known latency.

## Interface
Parameters:
- A_WIDTH, 17, width of signed operand din0 (2..27)
- B_WIDTH, 10, width of unsigned operand din1 (1..26)
- P_WIDTH, 26, width of signed result dout (2..A_WIDTH+B_WIDTH)
- NUM_STAGE, 3, pipeline latency in enabled cycles (1..4)
- SHIFT, 0, arithmetic right-shift applied to the full product (0..A_WIDTH+B_WIDTH-1)
- ROUND, 0, 1 = add 2^(SHIFT-1) before the shift (round half toward +inf); ignored when SHIFT=0
- SATURATE, 0, 1 = clamp on overflow; 0 = keep the low P_WIDTH bits (wrap)

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst  in  1  reset; synchronous, active-high
- ce  in  1  clock enable; 0 freezes every pipeline stage
- in_valid  in  1  din0/din1 qualify a new operation
- din0  in  A_WIDTH  signed multiplicand
- din1  in  B_WIDTH  unsigned multiplier (zero-extended internally)
- out_valid  out  1  dout/ovf are a result
- dout  out  P_WIDTH  signed result
- ovf  out  1  shifted result did not fit P_WIDTH (value in dout is clamped or wrapped)

## Operation
- Full product: F = signed(din0) × signed({1'b0, din1}), exactly A_WIDTH+B_WIDTH bits, no loss.
- Rounded: R = F + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed in A_WIDTH+B_WIDTH+1 bits.
- Shifted: S = R >>> SHIFT (arithmetic, sign-preserving).
- Range check: fits iff -2^(P_WIDTH-1) ≤ S ≤ 2^(P_WIDTH-1)-1; ovf = !fits.
- Output: fits → S; !fits && SATURATE → -2^(P_WIDTH-1) or 2^(P_WIDTH-1)-1 per sign of S; !fits && !SATURATE → S[P_WIDTH-1:0].
- Data registers load regardless of in_valid when ce=1; out_valid tracks in_valid through an identical valid chain. dout/ovf are don't-care when out_valid=0 but must not contain X after reset.
- ce=0: all data and valid registers hold; out_valid, dout, ovf hold their previous values.

## Timing
- Latency: a sample accepted at enabled edge k appears at enabled edge k+NUM_STAGE-1 outputs, i.e. visible after NUM_STAGE enabled edges. Throughput: one operation per enabled cycle.
- Stage mapping: stage 1 registers operands; multiply after stage 1; round/shift/clamp in final stage. NUM_STAGE=1: single output register after combinational multiply+post-process. NUM_STAGE=4: extra register between multiply and post-process.
- Reset: on ap_rst=1 at an edge, all valid bits, dout and ovf become 0 at that edge, irrespective of ce. Reset mid-pipeline discards in-flight operations; no out_valid pulse appears for data accepted before reset.
- ap_rst and ce both asserted: reset wins.
- in_valid asserted while ce=0: sample is not captured.

## Structure
- Package tc_mul_pkg: localparams for full-product width (A_WIDTH+B_WIDTH), rounded width, saturation max/min constants as functions of P_WIDTH; a function implementing the fit/clamp/wrap decision so TB model and RTL share it.
- Sub-module tc_mul_stage: one pipeline register (data width parameter + valid bit, ce, synchronous reset); instantiated NUM_STAGE times via generate.

## Test plan
- Defaults (17/10/26, NUM_STAGE=3): din0=-5, din1=7, in_valid=1 one cycle → out_valid=1 exactly 3 cycles later, dout=-35, ovf=0.
- Overflow, defaults: din0=-65536, din1=1023 (F=-67043328) → SATURATE=1: dout=-33554432, ovf=1; SATURATE=0: dout=65536, ovf=1.
- Rounding, SHIFT=4, ROUND=1, P_WIDTH=22: din0=25,din1=1 → dout=2; din0=-25,din1=1 → dout=-2; ROUND=0, din0=25 → dout=1.
- Back-to-back stream of 100 random operands with ce held 1, then ce toggled randomly → outputs match package model in order, none lost or duplicated, outputs frozen while ce=0.
- Reset mid-stream: 3 valid ops in flight, ap_rst pulsed one cycle (also with ce=0) → out_valid=0, dout=0, ovf=0 next cycle; no stale out_valid afterwards.
- Sweep NUM_STAGE=1..4 with din0=2^(A_WIDTH-1)-1, din1=2^B_WIDTH-1 → latency equals NUM_STAGE, value matches model.
